// File: rtl/mem_access_pkg.sv
// Shared opcodes, FSM states, access sizes and lane helpers for the MEM-stage
// load/store unit.
package mem_access_pkg;

    localparam int unsigned MEM_WORDS_DEFAULT = 512;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    // Big-endian lane offsets: byte offset 0 is the most significant byte
    localparam logic [1:0] OFF_BYTE0 = 2'd0;
    localparam logic [1:0] OFF_BYTE3 = 2'd3;
    localparam logic [4:0] HALF_HI_SHIFT = 5'd16;
    localparam logic [4:0] HALF_LO_SHIFT = 5'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RMW_RD,
        ST_WRITE,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b11
    } size_e;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: op_legal = 1'b1;
            default:             op_legal = 1'b0;
        endcase
    endfunction

    function automatic size_e op_size(input logic [3:0] op);
        case (op[1:0])
            2'b00:   op_size = SZ_BYTE;
            2'b01:   op_size = SZ_HALF;
            default: op_size = SZ_WORD;
        endcase
    endfunction

    // Bit position of a byte lane's LSB: (3 - offset) * 8
    function automatic logic [4:0] byte_shift(input logic [1:0] off);
        byte_shift = {~off, 3'b000};
    endfunction

    function automatic logic [4:0] half_shift(input logic [1:0] off);
        half_shift = off[1] ? HALF_LO_SHIFT : HALF_HI_SHIFT;
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane extraction/extension for loads and lane merge for
// read-modify-write stores on a big-endian word.
module byte_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [15:0] store_data_i,
    output logic [31:0] ext_data_c_o,
    output logic [31:0] merged_c_o
);

    logic [4:0]  shift;
    logic [31:0] mask;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        shift        = 5'd0;
        mask         = 32'hFFFF_FFFF;
        lane_b       = 8'h00;
        lane_h       = 16'h0000;
        ext_data_c_o = word_i;
        merged_c_o   = word_i;
        case (size_i)
            SZ_BYTE: begin
                shift        = byte_shift(offset_i);
                mask         = 32'h0000_00FF << shift;
                lane_b       = 8'(word_i >> shift);
                ext_data_c_o = unsigned_i ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
                merged_c_o   = (word_i & ~mask) | (32'(store_data_i[7:0]) << shift);
            end
            SZ_HALF: begin
                shift        = half_shift(offset_i);
                mask         = 32'h0000_FFFF << shift;
                lane_h       = 16'(word_i >> shift);
                ext_data_c_o = unsigned_i ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
                merged_c_o   = (word_i & ~mask) | (32'(store_data_i) << shift);
            end
            default: begin
                ext_data_c_o = word_i;
                merged_c_o   = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: drives a word-only data memory and builds
// byte/halfword accesses via lane extraction and read-modify-write.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Req_Valid,
    output logic        Req_Ready,
    input  logic [3:0]  Op,
    input  logic [31:0] Address,
    input  logic [31:0] Store_Data,
    output logic        Resp_Valid,
    output logic        Resp_Error,
    output logic [31:0] Load_Data,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_Write_Data,
    output logic        Mem_MemWrite,
    output logic        Mem_MemRead,
    input  logic [31:0] Mem_Read_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * MEM_WORDS);

    state_e      state_q;
    size_e       size_q;
    logic        uns_q;
    logic [1:0]  off_q;
    logic [15:0] st_data_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] load_data_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    size_e       size_d;
    logic        err_d;
    logic [31:0] ext_data;
    logic [31:0] merged_data;

    // Request decode and the alignment/range/opcode checks done at acceptance
    always_comb begin
        size_d = op_size(Op);
        err_d  = !op_legal(Op)
               || (Address >= ADDR_LIMIT)
               || ((size_d == SZ_HALF) && Address[0])
               || ((size_d == SZ_WORD) && (Address[1:0] != 2'b00));
    end

    byte_lane_align u_align (
        .word_i       (Mem_Read_data),
        .offset_i     (off_q),
        .size_i       (size_q),
        .unsigned_i   (uns_q),
        .store_data_i (st_data_q),
        .ext_data_c_o (ext_data),
        .merged_c_o   (merged_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            st_data_q    <= 16'h0000;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            load_data_q  <= 32'h0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Req_Valid) begin
                        size_q      <= size_d;
                        uns_q       <= Op[2];
                        off_q       <= Address[1:0];
                        st_data_q   <= Store_Data[15:0];
                        req_ready_q <= 1'b0;
                        if (err_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                        end else begin
                            mem_addr_q <= {Address[31:2], 2'b00};
                            if (!Op[3]) begin
                                state_q    <= ST_LOAD;
                                mem_read_q <= 1'b1;
                            end else if (size_d == SZ_WORD) begin
                                state_q     <= ST_WRITE;
                                mem_write_q <= 1'b1;
                                mem_wdata_q <= Store_Data;
                            end else begin
                                state_q    <= ST_RMW_RD;
                                mem_read_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_LOAD: begin
                    load_data_q  <= ext_data;
                    mem_read_q   <= 1'b0;
                    mem_addr_q   <= 32'h0;
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                end
                ST_RMW_RD: begin
                    mem_wdata_q <= merged_data;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b1;
                    state_q     <= ST_WRITE;
                end
                ST_WRITE: begin
                    mem_write_q  <= 1'b0;
                    mem_addr_q   <= 32'h0;
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_addr_q  <= 32'h0;
                end
            endcase
        end
    end

    assign Req_Ready      = req_ready_q;
    assign Resp_Valid     = resp_valid_q;
    assign Resp_Error     = resp_error_q;
    assign Load_Data      = load_data_q;
    assign Mem_Address    = mem_addr_q;
    assign Mem_Write_Data = mem_wdata_q;
    assign Mem_MemWrite   = mem_write_q;
    assign Mem_MemRead    = mem_read_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected
// responses; a negedge monitor pops and compares each Resp_Valid.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        CLK;
    logic        RESET;
    logic        Req_Valid;
    logic        Req_Ready;
    logic [3:0]  Op;
    logic [31:0] Address;
    logic [31:0] Store_Data;
    logic        Resp_Valid;
    logic        Resp_Error;
    logic [31:0] Load_Data;
    logic [31:0] Mem_Address;
    logic [31:0] Mem_Write_Data;
    logic        Mem_MemWrite;
    logic        Mem_MemRead;
    logic [31:0] Mem_Read_data;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          lat;
        int          rd;
        int          wr;
        int          acc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] exp_word_addr = 32'h0;

    logic [31:0] mem [0:511];
    logic        pre_we;
    logic [8:0]  pre_idx;
    logic [31:0] pre_data;

    mem_access_unit #(.MEM_WORDS(512)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Req_Valid      (Req_Valid),
        .Req_Ready      (Req_Ready),
        .Op             (Op),
        .Address        (Address),
        .Store_Data     (Store_Data),
        .Resp_Valid     (Resp_Valid),
        .Resp_Error     (Resp_Error),
        .Load_Data      (Load_Data),
        .Mem_Address    (Mem_Address),
        .Mem_Write_Data (Mem_Write_Data),
        .Mem_MemWrite   (Mem_MemWrite),
        .Mem_MemRead    (Mem_MemRead),
        .Mem_Read_data  (Mem_Read_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Word-addressed data memory; preload port only used while the DUT is idle
    assign Mem_Read_data = Mem_MemRead ? mem[Mem_Address[10:2]] : 32'h0;
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (Mem_MemWrite) mem[Mem_Address[10:2]] <= Mem_Write_Data;
        else if (pre_we)  mem[pre_idx] <= pre_data;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RESET) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (Mem_MemRead)  rd_cnt++;
            if (Mem_MemWrite) wr_cnt++;
            if (Mem_MemRead || Mem_MemWrite) check32("mem_address", Mem_Address, exp_word_addr);
            if (Resp_Valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got Resp_Valid=1 required 0");
                end else begin
                    mon_e = sb_q.pop_front();
                    check32("resp_error", 32'(Resp_Error), 32'(mon_e.err));
                    check32("load_data", Load_Data, mon_e.ld);
                    check32("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                    check32("read_cycles", 32'(rd_cnt), 32'(mon_e.rd));
                    check32("write_cycles", 32'(wr_cnt), 32'(mon_e.wr));
                end
                rd_cnt = 0;
                wr_cnt = 0;
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge CLK);
        while (Req_Ready !== 1'b1 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (Req_Ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got Req_Ready=%b required 1", Req_Ready);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge CLK);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout: got %0d pending responses required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic preload(input logic [8:0] idx, input logic [31:0] data);
        @(negedge CLK);
        pre_we   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        @(negedge CLK);
        pre_we   = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic err, input logic [31:0] ld, input int lat,
                         input int rd, input int wr);
        exp_t e;
        wait_ready();
        exp_word_addr = {addr[31:2], 2'b00};
        Op         = op;
        Address    = addr;
        Store_Data = sd;
        Req_Valid  = 1'b1;
        e.err = err;
        e.ld  = ld;
        e.lat = lat;
        e.rd  = rd;
        e.wr  = wr;
        e.acc = cyc;
        sb_q.push_back(e);
        @(posedge CLK);
        #1 Req_Valid = 1'b0;
    endtask

    initial begin
        RESET      = 1'b1;
        Req_Valid  = 1'b0;
        Op         = 4'h0;
        Address    = 32'h0;
        Store_Data = 32'h0;
        pre_we     = 1'b0;
        pre_idx    = 9'h0;
        pre_data   = 32'h0;
        #12;
        check32("rst_req_ready", 32'(Req_Ready), 32'd1);
        check32("rst_resp_valid", 32'(Resp_Valid), 32'd0);
        check32("rst_resp_error", 32'(Resp_Error), 32'd0);
        check32("rst_memwrite", 32'(Mem_MemWrite), 32'd0);
        check32("rst_memread", 32'(Mem_MemRead), 32'd0);
        check32("rst_load_data", Load_Data, 32'h0);
        check32("rst_mem_address", Mem_Address, 32'h0);
        check32("rst_mem_wdata", Mem_Write_Data, 32'h0);
        @(negedge CLK);
        RESET = 1'b0;

        preload(9'd4, 32'h8899AABB);
        preload(9'd511, 32'h0BADF00D);

        // Loads: lane extraction and extension
        issue(OP_LB,  32'h11, 32'h0, 1'b0, 32'hFFFFFF99, 2, 1, 0);
        issue(OP_LBU, 32'h11, 32'h0, 1'b0, 32'h00000099, 2, 1, 0);
        issue(OP_LH,  32'h12, 32'h0, 1'b0, 32'hFFFFAABB, 2, 1, 0);
        issue(OP_LHU, 32'h10, 32'h0, 1'b0, 32'h00008899, 2, 1, 0);
        issue(OP_LW,  32'h10, 32'h0, 1'b0, 32'h8899AABB, 2, 1, 0);
        issue(OP_LW,  32'h7FC, 32'h0, 1'b0, 32'h0BADF00D, 2, 1, 0);

        // Stores: read-modify-write for subword, direct write for SW
        issue(OP_SB, 32'h13, 32'h12345677, 1'b0, 32'h0BADF00D, 3, 1, 1);
        wait_drain();
        check32("mem_after_sb", mem[4], 32'h8899AA77);
        preload(9'd4, 32'h8899AABB);
        issue(OP_SH, 32'h10, 32'h0000CAFE, 1'b0, 32'h0BADF00D, 3, 1, 1);
        wait_drain();
        check32("mem_after_sh", mem[4], 32'hCAFEAABB);
        issue(OP_SW, 32'h14, 32'hDEADBEEF, 1'b0, 32'h0BADF00D, 2, 0, 1);
        wait_drain();
        check32("mem_after_sw", mem[5], 32'hDEADBEEF);
        issue(OP_SB, 32'h14, 32'h00000011, 1'b0, 32'h0BADF00D, 3, 1, 1);
        wait_drain();
        check32("mem_after_sb0", mem[5], 32'h11ADBEEF);
        issue(OP_LB, 32'h10, 32'h0, 1'b0, 32'hFFFFFFCA, 2, 1, 0);

        // Error requests: immediate error response, no strobes, Load_Data held
        issue(OP_LW, 32'h06,  32'h0, 1'b1, 32'hFFFFFFCA, 1, 0, 0);
        issue(OP_LH, 32'h11,  32'h0, 1'b1, 32'hFFFFFFCA, 1, 0, 0);
        issue(OP_LW, 32'h800, 32'h0, 1'b1, 32'hFFFFFFCA, 1, 0, 0);
        issue(4'h7,  32'h10,  32'h0, 1'b1, 32'hFFFFFFCA, 1, 0, 0);
        issue(OP_SW, 32'h800, 32'h13572468, 1'b1, 32'hFFFFFFCA, 1, 0, 0);
        wait_drain();
        check32("mem_after_err_sw", mem[5], 32'h11ADBEEF);

        // Reset during the WRITE cycle of an SB drops the write and the response
        wait_ready();
        exp_word_addr = 32'h10;
        Op         = OP_SB;
        Address    = 32'h13;
        Store_Data = 32'h00000055;
        Req_Valid  = 1'b1;
        @(posedge CLK);
        #1 Req_Valid = 1'b0;
        @(posedge CLK);
        #2;
        check32("pre_rst_memwrite", 32'(Mem_MemWrite), 32'd1);
        RESET = 1'b1;
        #1;
        check32("mid_rst_memwrite", 32'(Mem_MemWrite), 32'd0);
        check32("mid_rst_mem_address", Mem_Address, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check32("post_rst_req_ready", 32'(Req_Ready), 32'd1);
        check32("post_rst_load_data", Load_Data, 32'h0);
        check32("mem_after_rst", mem[4], 32'hCAFEAABB);
        repeat (3) @(negedge CLK);
        issue(OP_LW, 32'h10, 32'h0, 1'b0, 32'hCAFEAABB, 2, 1, 0);
        wait_drain();
        repeat (2) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
